stream_uart_bridge: RTL and testbench
=====================================

STREAM_UART_BRIDGE -- requirements
Module: stream_uart_bridge
Interface
REQ-001 Param DATA_W, 8, character width, 1..15.
REQ-002 Param WDEPTH, 64, write (tx) FIFO entries, power of two, 2..256.
REQ-003 Param RDEPTH, 64, read (rx) FIFO entries, power of two, 2..256.
REQ-004 Param TX_THRESH, 8, write-IRQ level: pending when wfifo used <= TX_THRESH.
REQ-005 Param RX_THRESH, 1, read-IRQ level: pending when rfifo used >= RX_THRESH.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 av_address  in  1  0=DATA, 1=CONTROL.
REQ-009 av_chipselect  in  1  slave select.
REQ-010 av_read_n  in  1  read strobe, active-low.
REQ-011 av_write_n  in  1  write strobe, active-low.
REQ-012 av_writedata  in  32  write word.
REQ-013 av_readdata  out  32  read word, valid while av_waitrequest low.
REQ-014 av_waitrequest  out  1  access stall.
REQ-015 av_irq  out  1  level interrupt.
REQ-016 tx_data  out  DATA_W  write-FIFO head.
REQ-017 tx_valid  out  1  write FIFO non-empty.
REQ-018 tx_ready  in  1  sink accepts tx_data.
REQ-019 rx_data  in  DATA_W  incoming character.
REQ-020 rx_valid  in  1  rx_data valid.
REQ-021 rx_ready  out  1  read FIFO not full.
REQ-022 dataavailable  out  1  registered read-FIFO non-empty.
REQ-023 readyfordata  out  1  registered write-FIFO non-full.
Function
REQ-024 Access = chipselect & (~read_n | ~write_n); waitrequest high on first access cycle, low on second (completion edge), high again after; exactly one side effect per access.
REQ-025 DATA read: pop rfifo if non-empty; readdata = {RAVAIL[15:0] (used after pop), RVALID bit15, zeros, data[DATA_W-1:0]}; if empty: RVALID=0, data=0, no pop.
REQ-026 DATA write: push writedata[DATA_W-1:0] if wfifo not full; else drop and set sticky WOVF.
REQ-027 CONTROL read: bit0 RE, bit1 WE, bit8 RI, bit9 WI, bit10 AC, bit14 WOVF, bits[31:16] WSPACE (WDEPTH - used), others 0.
REQ-028 CONTROL write: bits0/1 load RE/WE; bit10=1 clears AC; bit14=1 clears WOVF; 0 bits leave AC/WOVF unchanged.
REQ-029 RI = RE & (rfifo used >= RX_THRESH); WI = WE & (wfifo used <= TX_THRESH); both registered, one cycle after count change; av_irq = RI | WI.
REQ-030 tx_valid = ~wfifo_empty; tx pop on tx_valid & tx_ready; rx_ready = ~rfifo_full; rx push on rx_valid & rx_ready.
REQ-031 Same-cycle push and pop on one FIFO both take effect, used unchanged; pointers wrap mod depth; used width clog2(depth)+1, never over/underflows.
REQ-032 AC set on any tx pop or rx push; set wins over same-cycle clear.
REQ-033 dataavailable/readyfordata are registered copies of ~rfifo_empty/~wfifo_full, one-cycle lag.
Reset
REQ-034 While rst_n low at a clock edge: FIFOs emptied, RE/WE/AC/WOVF/RI/WI=0, av_waitrequest=1, av_readdata=0, av_irq=0, dataavailable=0, readyfordata=0; in-flight access abandoned with no side effect.
REQ-035 readyfordata rises the first edge after rst_n returns high.
Configuration
REQ-036 With STREAM_UART_BRIDGE_LOOPBACK_EN defined: CONTROL bit12 LOOPBACK (reset 0); when 1, wfifo head moves to rfifo each cycle both non-empty/non-full, tx_valid=0, rx_ready=0, AC set per move.
REQ-037 Without STREAM_UART_BRIDGE_LOOPBACK_EN: bit12 reads 0, writes ignored, no loopback logic.
Verification
REQ-038 Reset, read CONTROL -> readdata=0x00400000 (WSPACE=64), av_irq=0, tx_valid=0.
REQ-039 Write DATA 0x41 with tx_ready=0 -> tx_valid=1, tx_data=0x41, WSPACE=63; tx_ready=1 one cycle -> tx_valid=0, AC=1.
REQ-040 Push rx 0x5A, 0x5B; read DATA twice -> 0x00018000|0x5A then 0x00008000|0x5B; third read -> 0x00000000.
REQ-041 Fill wfifo with 64 writes, write 65th -> dropped, WOVF=1, readyfordata=0; write CONTROL 0x4000 -> WOVF=0.
REQ-042 RE=1, push 1 rx char -> av_irq=1 next cycle; read DATA -> av_irq=0 one cycle after pop.
REQ-043 Simultaneous rx push and DATA read with 3 entries -> RAVAIL=2 in readdata, used stays 3.

Source files
------------

// File: rtl/stream_uart_bridge.sv
// Avalon-MM slave bridging a 32-bit register interface to a pair of character
// streams through a write (tx) FIFO and a read (rx) FIFO.
// Each bus access takes two cycles and has exactly one side effect, applied
// on the edge that completes it.
// Optional feature: define STREAM_UART_BRIDGE_LOOPBACK_EN to add CONTROL
// bit12 LOOPBACK, which moves characters from the tx FIFO to the rx FIFO.
module stream_uart_bridge #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WDEPTH    = 64,
  parameter int unsigned RDEPTH    = 64,
  parameter int unsigned TX_THRESH = 8,
  parameter int unsigned RX_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              av_address,
  input  logic              av_chipselect,
  input  logic              av_read_n,
  input  logic              av_write_n,
  input  logic [31:0]       av_writedata,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic              av_irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              dataavailable,
  output logic              readyfordata
);

  localparam int unsigned WAW = $clog2(WDEPTH);
  localparam int unsigned RAW = $clog2(RDEPTH);
  localparam int unsigned WCW = WAW + 1;
  localparam int unsigned RCW = RAW + 1;

  localparam logic [WCW-1:0] WDepthC = WCW'(WDEPTH);
  localparam logic [RCW-1:0] RDepthC = RCW'(RDEPTH);
  localparam logic [WCW-1:0] TxThrC  = WCW'(TX_THRESH);
  localparam logic [RCW-1:0] RxThrC  = RCW'(RX_THRESH);

  typedef enum logic [0:0] {StIdle, StDone} acc_st_e;

  acc_st_e st_q, st_d;

  logic access, done, rd_done, wr_done;
  logic data_rd, ctrl_rd, data_wr, ctrl_wr;

  // Write FIFO
  logic [DATA_W-1:0] wmem [WDEPTH];
  logic [WAW-1:0]    wwp_q, wrp_q;
  logic [WCW-1:0]    wused_q, wused_d;
  logic              wempty, wfull, wpush, wpop;

  // Read FIFO
  logic [DATA_W-1:0] rmem [RDEPTH];
  logic [RAW-1:0]    rwp_q, rrp_q;
  logic [RCW-1:0]    rused_q, rused_d;
  logic              rempty, rfull, rpush, rpop;
  logic [DATA_W-1:0] rpush_data, rhead;

  // Control / status
  logic re_q, we_q, ac_q, wovf_q, ri_q, wi_q;
  logic dataavailable_q, readyfordata_q;
  logic [RCW-1:0] ravail;
  logic [WCW-1:0] wspace;
  logic [31:0]    rdata;

  assign access  = av_chipselect & (~av_read_n | ~av_write_n);
  assign done    = (st_q == StDone) & access;
  assign rd_done = done & ~av_read_n;
  assign wr_done = done & av_read_n & ~av_write_n;
  assign data_rd = rd_done & ~av_address;
  assign ctrl_rd = rd_done & av_address;
  assign data_wr = wr_done & ~av_address;
  assign ctrl_wr = wr_done & av_address;

  assign wempty = (wused_q == '0);
  assign wfull  = (wused_q == WDepthC);
  assign rempty = (rused_q == '0);
  assign rfull  = (rused_q == RDepthC);

  assign wpush = data_wr & ~wfull;
  assign rpop  = data_rd & ~rempty;

  assign tx_data = wmem[wrp_q];
  assign rhead   = rmem[rrp_q];

`ifdef STREAM_UART_BRIDGE_LOOPBACK_EN
  logic lb_q, lb_move;

  // In loopback the external streams are shut off and the FIFO heads are joined.
  assign lb_move    = lb_q & ~wempty & ~rfull;
  assign tx_valid   = ~wempty & ~lb_q;
  assign rx_ready   = ~rfull & ~lb_q;
  assign wpop       = lb_move | (tx_valid & tx_ready);
  assign rpush      = lb_move | (rx_valid & rx_ready);
  assign rpush_data = lb_move ? tx_data : rx_data;

  // Loopback enable register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lb_q <= 1'b0;
    end else if (ctrl_wr) begin
      lb_q <= av_writedata[12];
    end
  end
`else
  assign tx_valid   = ~wempty;
  assign rx_ready   = ~rfull;
  assign wpop       = tx_valid & tx_ready;
  assign rpush      = rx_valid & rx_ready;
  assign rpush_data = rx_data;
`endif

  // Access sequencer: one stall cycle, then one completion cycle.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (access) st_d = StDone;
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  // Access state register
  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= StIdle;
    else        st_q <= st_d;
  end

  assign av_waitrequest = (st_q != StDone);

  // FIFO occupancy next-state; simultaneous push and pop cancel out.
  always_comb begin
    wused_d = wused_q;
    if (wpush && !wpop)      wused_d = wused_q + WCW'(1);
    else if (!wpush && wpop) wused_d = wused_q - WCW'(1);
    rused_d = rused_q;
    if (rpush && !rpop)      rused_d = rused_q + RCW'(1);
    else if (!rpush && rpop) rused_d = rused_q - RCW'(1);
  end

  // FIFO pointers and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wwp_q   <= '0;
      wrp_q   <= '0;
      wused_q <= '0;
      rwp_q   <= '0;
      rrp_q   <= '0;
      rused_q <= '0;
    end else begin
      if (wpush) wwp_q <= wwp_q + WAW'(1);
      if (wpop)  wrp_q <= wrp_q + WAW'(1);
      if (rpush) rwp_q <= rwp_q + RAW'(1);
      if (rpop)  rrp_q <= rrp_q + RAW'(1);
      wused_q <= wused_d;
      rused_q <= rused_d;
    end
  end

  // FIFO storage, not reset: contents are only visible through the counters.
  always_ff @(posedge clk) begin
    if (wpush) wmem[wwp_q] <= av_writedata[DATA_W-1:0];
    if (rpush) rmem[rwp_q] <= rpush_data;
  end

  // Control, status and interrupt registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      re_q            <= 1'b0;
      we_q            <= 1'b0;
      ac_q            <= 1'b0;
      wovf_q          <= 1'b0;
      ri_q            <= 1'b0;
      wi_q            <= 1'b0;
      dataavailable_q <= 1'b0;
      readyfordata_q  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        re_q <= av_writedata[0];
        we_q <= av_writedata[1];
      end
      // Activity set has priority over a software clear in the same cycle.
      if (wpop || rpush)                  ac_q <= 1'b1;
      else if (ctrl_wr && av_writedata[10]) ac_q <= 1'b0;
      if (data_wr && wfull)                 wovf_q <= 1'b1;
      else if (ctrl_wr && av_writedata[14]) wovf_q <= 1'b0;
      ri_q            <= re_q & (rused_q >= RxThrC);
      wi_q            <= we_q & (wused_q <= TxThrC);
      dataavailable_q <= ~rempty;
      readyfordata_q  <= ~wfull;
    end
  end

  assign ravail = rused_q - RCW'(1);
  assign wspace = WDepthC - wused_q;

  // Read data mux, driven only during the completion cycle of a read.
  always_comb begin
    rdata = '0;
    if (data_rd) begin
      if (!rempty) begin
        rdata[31:16]       = 16'(ravail);
        rdata[15]          = 1'b1;
        rdata[DATA_W-1:0]  = rhead;
      end
    end else if (ctrl_rd) begin
      rdata[0]     = re_q;
      rdata[1]     = we_q;
      rdata[8]     = ri_q;
      rdata[9]     = wi_q;
      rdata[10]    = ac_q;
`ifdef STREAM_UART_BRIDGE_LOOPBACK_EN
      rdata[12]    = lb_q;
`endif
      rdata[14]    = wovf_q;
      rdata[31:16] = 16'(wspace);
    end
  end

  assign av_readdata   = rdata;
  assign av_irq        = ri_q | wi_q;
  assign dataavailable = dataavailable_q;
  assign readyfordata  = readyfordata_q;

endmodule

// File: tb/tb_stream_uart_bridge.sv
// Scoreboard bench for stream_uart_bridge: stimulus queues expected bus read
// data and tx characters; a negedge monitor pops and compares them.
module tb_stream_uart_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        av_address, av_chipselect, av_read_n, av_write_n;
  logic [31:0] av_writedata, av_readdata;
  logic        av_waitrequest, av_irq;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic        dataavailable, readyfordata;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rd[$];
  logic [7:0]  exp_tx[$];

  always #5 clk = ~clk;

  stream_uart_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .av_address     (av_address),
    .av_chipselect  (av_chipselect),
    .av_read_n      (av_read_n),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest),
    .av_irq         (av_irq),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .dataavailable  (dataavailable),
    .readyfordata   (readyfordata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare completed reads and accepted tx characters.
  always @(negedge clk) begin
    if (rst_n && av_chipselect && !av_read_n && !av_waitrequest) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", av_readdata);
      end else begin
        chk("av_readdata", av_readdata, exp_rd.pop_front());
      end
    end
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got 0x%02h expected no character", tx_data);
      end else begin
        chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  // One bus access; optionally pulses an rx push on the completion edge.
  task automatic bus(input logic rd, input logic addr, input logic [31:0] wdata,
                     input logic [31:0] exp, input bit rx_at_done, input logic [7:0] rxd);
    int n;
    bit ok;
    @(posedge clk);
    #1;
    av_chipselect = 1'b1;
    av_address    = addr;
    if (rd) begin
      av_read_n = 1'b0;
      exp_rd.push_back(exp);
    end else begin
      av_write_n   = 1'b0;
      av_writedata = wdata;
    end
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (!av_waitrequest) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: got waitrequest=1 expected 0 within 20 cycles");
      if (rd) void'(exp_rd.pop_back());
    end else if (rx_at_done) begin
      rx_valid = 1'b1;
      rx_data  = rxd;
    end
    @(posedge clk);
    #1;
    av_chipselect = 1'b0;
    av_read_n     = 1'b1;
    av_write_n    = 1'b1;
    rx_valid      = 1'b0;
  endtask

  task automatic rd(input logic addr, input logic [31:0] exp);
    bus(1'b1, addr, 32'h0, exp, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic addr, input logic [31:0] data);
    bus(1'b0, addr, data, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic rx_push(input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    av_address    = 1'b0;
    av_chipselect = 1'b0;
    av_read_n     = 1'b1;
    av_write_n    = 1'b1;
    av_writedata  = 32'h0;
    tx_ready      = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_waitrequest", 32'(av_waitrequest), 32'd1);
    chk("rst_irq", 32'(av_irq), 32'd0);
    chk("rst_readdata", av_readdata, 32'h0);
    chk("rst_readyfordata", 32'(readyfordata), 32'd0);
    chk("rst_dataavailable", 32'(dataavailable), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("readyfordata_rise", 32'(readyfordata), 32'd1);

    // Idle CONTROL
    rd(1'b1, 32'h0040_0000);
    chk("idle_irq", 32'(av_irq), 32'd0);
    chk("idle_tx_valid", 32'(tx_valid), 32'd0);

    // Single tx character
    wr(1'b0, 32'h41);
    @(negedge clk);
    chk("tx_valid_set", 32'(tx_valid), 32'd1);
    chk("tx_data_head", 32'(tx_data), 32'h41);
    rd(1'b1, 32'h003F_0000);
    exp_tx.push_back(8'h41);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    chk("tx_valid_clr", 32'(tx_valid), 32'd0);
    rd(1'b1, 32'h0040_0400);
    wr(1'b1, 32'h0000_0400);
    rd(1'b1, 32'h0040_0000);

    // Two rx characters, then an empty read
    rx_push(8'h5A);
    rx_push(8'h5B);
    @(negedge clk);
    chk("dataavailable_set", 32'(dataavailable), 32'd1);
    rd(1'b0, 32'h0001_805A);
    rd(1'b0, 32'h0000_805B);
    rd(1'b0, 32'h0000_0000);
    repeat (2) @(negedge clk);
    chk("dataavailable_clr", 32'(dataavailable), 32'd0);
    wr(1'b1, 32'h0000_0400);

    // Fill the tx FIFO and overflow it
    for (int i = 0; i < 64; i++) wr(1'b0, 32'(i));
    @(posedge clk);
    @(negedge clk);
    chk("readyfordata_full", 32'(readyfordata), 32'd0);
    wr(1'b0, 32'hEE);
    rd(1'b1, 32'h0000_4000);
    wr(1'b1, 32'h0000_4000);
    rd(1'b1, 32'h0000_0000);

    // Drain: exactly the 64 accepted characters must come out
    for (int i = 0; i < 64; i++) exp_tx.push_back(8'(i));
    @(posedge clk);
    #1 tx_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got tx_valid=1 expected 0 within 200 cycles");
    end
    @(posedge clk);
    #1 tx_ready = 1'b0;
    chk("drain_left", 32'(exp_tx.size()), 32'd0);
    rd(1'b1, 32'h0040_0400);
    wr(1'b1, 32'h0000_0400);

    // Read interrupt timing
    wr(1'b1, 32'h0000_0001);
    repeat (2) @(negedge clk);
    chk("ri_idle", 32'(av_irq), 32'd0);
    rx_push(8'h33);
    @(negedge clk);
    chk("ri_lag", 32'(av_irq), 32'd0);
    @(negedge clk);
    chk("ri_set", 32'(av_irq), 32'd1);
    rd(1'b0, 32'h0000_8033);
    @(negedge clk);
    chk("ri_hold", 32'(av_irq), 32'd1);
    @(negedge clk);
    chk("ri_clr", 32'(av_irq), 32'd0);

    // Write interrupt with empty tx FIFO
    wr(1'b1, 32'h0000_0002);
    repeat (2) @(negedge clk);
    chk("wi_set", 32'(av_irq), 32'd1);
    rd(1'b1, 32'h0040_0602);
    wr(1'b1, 32'h0000_0400);
    rd(1'b1, 32'h0040_0000);
    chk("wi_clr", 32'(av_irq), 32'd0);

    // Simultaneous rx push and DATA read with three entries
    rx_push(8'h10);
    rx_push(8'h11);
    rx_push(8'h12);
    bus(1'b1, 1'b0, 32'h0, 32'h0002_8010, 1'b1, 8'h13);
    rd(1'b0, 32'h0002_8011);
    rd(1'b0, 32'h0001_8012);
    rd(1'b0, 32'h0000_8013);
    rd(1'b0, 32'h0000_0000);

    repeat (2) @(negedge clk);
    chk("rd_queue_left", 32'(exp_rd.size()), 32'd0);
    chk("tx_queue_left", 32'(exp_tx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
